// File: rtl/sin_pwm.sv
// sin_pwm: converts a 9-bit signed sine sample into a fixed-frequency PWM
// with complementary, dead-time-protected high/low gate drives.
//
// Ports:
//   clk          system clock
//   resetb       synchronous reset, active-high (despite the name)
//   en           run enable; low clears the run state and outputs on the next edge
//   sample       signed two's-complement sine sample, nominal -255..+255
//   pwm_h        high-side gate drive
//   pwm_l        low-side gate drive
//   period_start one-cycle pulse in the cycle where sample was latched
//   clip         sticky: a -256 sample was latched; cleared by reset or en low
//
// Period is 512 clk. The sample is latched only at period start, so the
// upstream generator may change it at any time without disturbing duty.
module sin_pwm #(
    parameter int unsigned DEAD = 4
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       en,
    input  logic [8:0] sample,
    output logic       pwm_h,
    output logic       pwm_l,
    output logic       period_start,
    output logic       clip
);

    localparam logic [4:0] DEAD_L        = 5'(DEAD);
    localparam logic [4:0] RUN_MAX       = 5'd31;
    localparam logic [8:0] SAMPLE_NEG_FS = 9'h100;

    logic [8:0] cnt;
    logic [9:0] duty_q;
    logic       run;
    logic [4:0] hi_run;
    logic [4:0] lo_run;

    logic       raw;
    logic       sample_clip;
    logic [9:0] duty_d;
    logic [4:0] hi_next;
    logic [4:0] lo_next;

    always_comb begin
        raw         = run & ({1'b0, cnt} < duty_q);
        sample_clip = (sample == SAMPLE_NEG_FS);
        // -256 folds to -255, then offset by +256: duty spans 1..511, so both
        // phases exist in every period.
        duty_d      = sample_clip ? 10'd1 : ({sample[8], sample} + 10'd256);
        hi_next     = '0;
        lo_next     = '0;
        if (raw) begin
            hi_next = (hi_run == RUN_MAX) ? RUN_MAX : hi_run + 5'd1;
        end else begin
            lo_next = (lo_run == RUN_MAX) ? RUN_MAX : lo_run + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            cnt          <= '0;
            duty_q       <= '0;
            run          <= 1'b0;
            hi_run       <= '0;
            lo_run       <= '0;
            pwm_h        <= 1'b0;
            pwm_l        <= 1'b0;
            period_start <= 1'b0;
            clip         <= 1'b0;
        end else if (!en) begin
            // Abort immediately; duty_q deliberately holds.
            run          <= 1'b0;
            cnt          <= '0;
            hi_run       <= '0;
            lo_run       <= '0;
            pwm_h        <= 1'b0;
            pwm_l        <= 1'b0;
            period_start <= 1'b0;
            clip         <= 1'b0;
        end else if (!run) begin
            run          <= 1'b1;
            cnt          <= '0;
            duty_q       <= duty_d;
            period_start <= 1'b1;
            clip         <= clip | sample_clip;
            pwm_h        <= 1'b0;
            pwm_l        <= 1'b0;
        end else begin
            cnt          <= cnt + 9'd1;
            // Run-lengths carry across the wrap: 511->0 is an ordinary edge.
            hi_run       <= hi_next;
            lo_run       <= lo_next;
            pwm_h        <= raw & (hi_next > DEAD_L);
            pwm_l        <= ~raw & run & (lo_next > DEAD_L);
            period_start <= (cnt == '1);
            if (cnt == '1) begin
                duty_q <= duty_d;
                clip   <= clip | sample_clip;
            end
        end
    end

    no_shoot_through: assert property (@(posedge clk) !(pwm_h && pwm_l));

endmodule

// File: tb/tb_sin_pwm.sv
// tb_sin_pwm: directed, table-driven bench for sin_pwm (DEAD=4).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_sin_pwm;

    logic       clk;
    logic       resetb;
    logic       en;
    logic [8:0] sample;
    logic       pwm_h;
    logic       pwm_l;
    logic       period_start;
    logic       clip;

    int checks = 0;
    int errors = 0;

    sin_pwm #(.DEAD(4)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .en           (en),
        .sample       (sample),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .period_start (period_start),
        .clip         (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before 2000000");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [8:0] s;
        int         h;
        int         l;
        int         both;
        int         clp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetb = 1'b1;
        en     = 1'b0;
        repeat (2) @(negedge clk);
        resetb = 1'b0;
    endtask

    task automatic wait_ps(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, int'(ok), 1);
    endtask

    // Starts on a period_start sample, ends on the next one.
    task automatic measure(output int h, output int l, output int both,
                           output int ovl, output int len);
        h = 0; l = 0; both = 0; ovl = 0; len = 0;
        do begin
            if (pwm_h) h++;
            if (pwm_l) l++;
            if (!pwm_h && !pwm_l) both++;
            if (pwm_h && pwm_l) ovl++;
            len++;
            @(negedge clk);
        end while (!period_start && len < 1100);
    endtask

    initial begin
        int h, l, both, ovl, len, ps_cnt;

        resetb = 1'b1;
        en     = 1'b0;
        sample = '0;

        vecs[0] = '{9'd0,   252, 252, 8, 0};
        vecs[1] = '{9'd255, 507, 0,   5, 0};
        vecs[2] = '{9'h100, 0,   507, 5, 1};
        vecs[3] = '{9'h101, 0,   507, 5, 0};
        vecs[4] = '{9'd100, 352, 152, 8, 0};
        vecs[5] = '{9'h19C, 152, 352, 8, 0};
        vecs[6] = '{9'h104, 0,   504, 8, 0};
        vecs[7] = '{9'h105, 1,   503, 8, 0};
        vecs[8] = '{9'd251, 503, 1,   8, 0};
        vecs[9] = '{9'd252, 504, 0,   8, 0};

        // Reset state, with en held high during reset.
        en = 1'b1;
        @(negedge clk);
        check("rst_ps",   int'(period_start), 0);
        check("rst_h",    int'(pwm_h), 0);
        check("rst_l",    int'(pwm_l), 0);
        check("rst_clip", int'(clip), 0);
        resetb = 1'b0;
        @(negedge clk);
        check("first_ps",   int'(period_start), 1);
        check("first_h",    int'(pwm_h), 0);
        @(negedge clk);
        check("second_ps",  int'(period_start), 0);

        // Steady-state duty table.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            sample = vecs[i].s;
            en     = 1'b1;
            wait_ps($sformatf("v%0d_ps", i));
            measure(h, l, both, ovl, len);
            measure(h, l, both, ovl, len);
            check($sformatf("v%0d_len", i),  len, 512);
            check($sformatf("v%0d_h", i),    h, vecs[i].h);
            check($sformatf("v%0d_l", i),    l, vecs[i].l);
            check($sformatf("v%0d_both", i), both, vecs[i].both);
            check($sformatf("v%0d_ovl", i),  ovl, 0);
            check($sformatf("v%0d_clip", i), int'(clip), vecs[i].clp);
        end

        // Clip is sticky across a clean latch, cleared by en low.
        do_reset();
        sample = 9'h100;
        en     = 1'b1;
        wait_ps("clip_ps0");
        check("clip_set", int'(clip), 1);
        sample = 9'd0;
        wait_ps("clip_ps1");
        check("clip_sticky", int'(clip), 1);
        en = 1'b0;
        @(negedge clk);
        check("clip_clr", int'(clip), 0);
        check("clip_clr_ps", int'(period_start), 0);
        en = 1'b1;
        @(negedge clk);
        check("clip_rearm_ps", int'(period_start), 1);
        check("clip_rearm", int'(clip), 0);

        // Sample change mid-period only takes effect at the next latch.
        do_reset();
        sample = 9'd100;
        en     = 1'b1;
        wait_ps("mid_ps");
        h = 0; ps_cnt = 0;
        for (int pos = 0; pos < 512; pos++) begin
            if (pwm_h) h++;
            if (pos > 0 && period_start) ps_cnt++;
            if (pos == 200) sample = 9'h19C;
            @(negedge clk);
        end
        check("mid_h_old", h, 352);
        check("mid_no_ps", ps_cnt, 0);
        check("mid_ps_512", int'(period_start), 1);
        measure(h, l, both, ovl, len);
        check("mid_h_new", h, 152);
        check("mid_len", len, 512);

        // en drop while pwm_h is high, then restart with a new sample.
        do_reset();
        sample = 9'd100;
        en     = 1'b1;
        wait_ps("drop_ps");
        repeat (300) @(negedge clk);
        check("drop_h_before", int'(pwm_h), 1);
        en = 1'b0;
        @(negedge clk);
        check("drop_h", int'(pwm_h), 0);
        check("drop_l", int'(pwm_l), 0);
        check("drop_ps", int'(period_start), 0);
        sample = 9'h19C;
        en     = 1'b1;
        @(negedge clk);
        check("restart_ps", int'(period_start), 1);
        measure(h, l, both, ovl, len);
        check("restart_h", h, 152);
        check("restart_len", len, 512);

        // en falls on the wrap edge: no period_start.
        repeat (511) @(negedge clk);
        check("wrap_pre_ps", int'(period_start), 0);
        en = 1'b0;
        @(negedge clk);
        check("wrap_ps", int'(period_start), 0);
        check("wrap_h", int'(pwm_h), 0);
        check("wrap_l", int'(pwm_l), 0);
        en = 1'b1;
        @(negedge clk);
        check("wrap_restart_ps", int'(period_start), 1);

        // Reset mid-period with en held high.
        do_reset();
        sample = 9'h100;
        en     = 1'b1;
        wait_ps("mrst_ps");
        repeat (100) @(negedge clk);
        check("mrst_l_before", int'(pwm_l), 1);
        check("mrst_clip_before", int'(clip), 1);
        resetb = 1'b1;
        @(negedge clk);
        check("mrst_h", int'(pwm_h), 0);
        check("mrst_l", int'(pwm_l), 0);
        check("mrst_ps", int'(period_start), 0);
        check("mrst_clip", int'(clip), 0);
        resetb = 1'b0;
        sample = 9'd0;
        @(negedge clk);
        check("mrst_restart_ps", int'(period_start), 1);
        measure(h, l, both, ovl, len);
        check("mrst_len", len, 512);
        check("mrst_h_period", h, 252);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
